// File: rtl/path_delay_meas_ctrl_if.sv
// Host-side handshake and result bundle of the path delay measurement controller.
// The controller connects through the slave modport; the host (or a bench)
// connects through the master modport.
interface path_delay_meas_ctrl_if #(
    parameter int CNT_W   = 8,
    parameter int TRIAL_W = 4
);
    logic                       start;
    logic [TRIAL_W-1:0]         num_trials;
    logic [CNT_W-1:0]           thresh_lo;
    logic [CNT_W-1:0]           thresh_hi;
    logic                       busy;
    logic                       done;
    logic [CNT_W+TRIAL_W-1:0]   result_sum;
    logic [CNT_W-1:0]           result_min;
    logic [CNT_W-1:0]           result_max;
    logic                       timeout;
    logic                       alarm;

    modport master (
        output start, num_trials, thresh_lo, thresh_hi,
        input  busy, done, result_sum, result_min, result_max, timeout, alarm
    );

    modport slave (
        input  start, num_trials, thresh_lo, thresh_hi,
        output busy, done, result_sum, result_min, result_max, timeout, alarm
    );
endinterface

// File: rtl/path_delay_meas_ctrl.sv
// Repeated launch-to-arrival delay measurement of an external delay path.
// Each trial waits for the path to settle, toggles path_input (rising on even
// trials, falling on odd ones) and counts clock edges until the synchronised
// path_result shows the new settled value. Sum/min/max of the samples and an
// out-of-window / no-response alarm are reported with a one-cycle done pulse.
module path_delay_meas_ctrl #(
    parameter int CNT_W          = 8,
    parameter int TRIAL_W        = 4,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int SETTLE_CYCLES  = 16,
    parameter bit INVERTING      = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    path_delay_meas_ctrl_if.slave       bus,
    output logic                        path_input,
    input  logic                        path_result
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RECORD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES);
    localparam int               SUM_W        = CNT_W + TRIAL_W;

    state_t               state_r;
    logic                 sync1_r, sync2_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [TRIAL_W-1:0]   idx_r, ntr_r;
    logic [CNT_W-1:0]     lo_r, hi_r;
    logic [SUM_W-1:0]     acc_r;
    logic [CNT_W-1:0]     min_r, max_r;
    logic                 path_input_r;
    logic                 busy_r, done_r, timeout_r, alarm_r;
    logic [SUM_W-1:0]     res_sum_r;
    logic [CNT_W-1:0]     res_min_r, res_max_r;

    logic                 expected_s;
    logic [SUM_W-1:0]     sum_nxt_s;
    logic [CNT_W-1:0]     min_nxt_s, max_nxt_s;
    logic [TRIAL_W-1:0]   idx_nxt_s;

    // Settled value of the path for the current drive, and the statistics after folding in the frozen sample.
    always_comb begin
        expected_s = path_input_r ^ INVERTING;
        sum_nxt_s  = acc_r + {{TRIAL_W{1'b0}}, cnt_r};
        min_nxt_s  = (cnt_r < min_r) ? cnt_r : min_r;
        max_nxt_s  = (cnt_r > max_r) ? cnt_r : max_r;
        idx_nxt_s  = idx_r + {{(TRIAL_W-1){1'b0}}, 1'b1};
    end

    // Two-flop synchroniser bringing the asynchronous path output into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= path_result;
            sync2_r <= sync1_r;
        end
    end

    // Measurement sequencer: trial loop, statistics accumulation and registered result reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= {TRIAL_W{1'b0}};
            ntr_r        <= {TRIAL_W{1'b0}};
            lo_r         <= {CNT_W{1'b0}};
            hi_r         <= {CNT_W{1'b0}};
            acc_r        <= {SUM_W{1'b0}};
            min_r        <= {CNT_W{1'b0}};
            max_r        <= {CNT_W{1'b0}};
            path_input_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            timeout_r    <= 1'b0;
            alarm_r      <= 1'b0;
            res_sum_r    <= {SUM_W{1'b0}};
            res_min_r    <= {CNT_W{1'b0}};
            res_max_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        ntr_r   <= (bus.num_trials == {TRIAL_W{1'b0}}) ?
                                   {{(TRIAL_W-1){1'b0}}, 1'b1} : bus.num_trials;
                        lo_r    <= bus.thresh_lo;
                        hi_r    <= bus.thresh_hi;
                        acc_r   <= {SUM_W{1'b0}};
                        min_r   <= {CNT_W{1'b1}};
                        max_r   <= {CNT_W{1'b0}};
                        idx_r   <= {TRIAL_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        if (sync2_r != expected_s) begin
                            // Path not at its settled value: report partial results and abort.
                            res_sum_r    <= acc_r;
                            res_min_r    <= (idx_r == {TRIAL_W{1'b0}}) ? {CNT_W{1'b0}} : min_r;
                            res_max_r    <= max_r;
                            timeout_r    <= 1'b1;
                            alarm_r      <= 1'b1;
                            done_r       <= 1'b1;
                            path_input_r <= 1'b0;
                            state_r      <= S_DONE;
                        end else begin
                            state_r <= S_LAUNCH;
                        end
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_LAUNCH: begin
                    // Even trials launch a rising edge, odd trials a falling edge.
                    path_input_r <= ~idx_r[0];
                    cnt_r        <= {CNT_W{1'b0}};
                    state_r      <= S_WAIT;
                end
                S_WAIT: begin
                    if (sync2_r == expected_s) begin
                        // Arrival wins over a simultaneous limit hit; cnt_r is frozen as the sample.
                        state_r <= S_RECORD;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        res_sum_r    <= acc_r;
                        res_min_r    <= (idx_r == {TRIAL_W{1'b0}}) ? {CNT_W{1'b0}} : min_r;
                        res_max_r    <= max_r;
                        timeout_r    <= 1'b1;
                        alarm_r      <= 1'b1;
                        done_r       <= 1'b1;
                        path_input_r <= 1'b0;
                        state_r      <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_RECORD: begin
                    acc_r <= sum_nxt_s;
                    min_r <= min_nxt_s;
                    max_r <= max_nxt_s;
                    idx_r <= idx_nxt_s;
                    cnt_r <= {CNT_W{1'b0}};
                    if (idx_nxt_s == ntr_r) begin
                        res_sum_r    <= sum_nxt_s;
                        res_min_r    <= min_nxt_s;
                        res_max_r    <= max_nxt_s;
                        timeout_r    <= 1'b0;
                        alarm_r      <= (max_nxt_s > hi_r) || (min_nxt_s < lo_r);
                        done_r       <= 1'b1;
                        path_input_r <= 1'b0;
                        state_r      <= S_DONE;
                    end else begin
                        state_r <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    // done and busy fall together; a start seen in this cycle is dropped.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign path_input     = path_input_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.result_sum = res_sum_r;
    assign bus.result_min = res_min_r;
    assign bus.result_max = res_max_r;
    assign bus.timeout    = timeout_r;
    assign bus.alarm      = alarm_r;
endmodule

// File: tb/tb_path_delay_meas_ctrl.sv
// Bench for path_delay_meas_ctrl: an external inverting delay path with
// independent rise/fall delays (or a stuck output) is modelled around the DUT,
// and every measurement is compared against sample = delay + 2 arithmetic.
`timescale 1ns/1ps
module tb_path_delay_meas_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic path_input;
    logic path_result;

    path_delay_meas_ctrl_if #(.CNT_W(8), .TRIAL_W(4)) bus ();

    path_delay_meas_ctrl #(
        .CNT_W(8), .TRIAL_W(4), .TIMEOUT_CYCLES(200),
        .SETTLE_CYCLES(16), .INVERTING(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .path_input(path_input), .path_result(path_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int done_cnt = 0;
    int last_latency = 0;

    // path model controls
    int   rise_d = 0;
    int   fall_d = 0;
    logic stuck_en = 1'b0;
    logic stuck_val = 1'b0;
    logic [7:0] hist;
    logic tap_r, tap_f, raw;

    // hist[k] holds path_input as it was k+1 edges ago
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 8'd0;
        else        hist <= {hist[6:0], path_input};
    end

    // inverting path: output edge follows a rising input after rise_d, falling after fall_d
    always_comb begin
        tap_r = (rise_d == 0) ? path_input : hist[3'(rise_d - 1)];
        tap_f = (fall_d == 0) ? path_input : hist[3'(fall_d - 1)];
        raw   = (rise_d <= fall_d) ? (tap_r | tap_f) : (tap_r & tap_f);
        path_result = stuck_en ? stuck_val : ~raw;
    end

    always @(posedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference: trial i samples (rise or fall delay) + 2 synchroniser edges
    function automatic void model(input int ntr, input int lo, input int hi,
                                  output int s, output int mn, output int mx, output bit al);
        int n;
        int smp;
        n  = (ntr == 0) ? 1 : ntr;
        s  = 0; mn = 255; mx = 0;
        for (int i = 0; i < n; i++) begin
            smp = ((i % 2) == 0) ? rise_d + 2 : fall_d + 2;
            s  += smp;
            if (smp < mn) mn = smp;
            if (smp > mx) mx = smp;
        end
        al = (mx > hi) || (mn < lo);
    endfunction

    // one measurement: start, wait (bounded) for done, check results, check idle afterwards
    task automatic run_meas(input string tag, input int ntr, input int lo, input int hi,
                            input int extra_at, input bit start_on_done,
                            input int e_sum, input int e_min, input int e_max,
                            input bit e_to, input bit e_al);
        int cyc;
        bit seen;
        @(negedge clk);
        bus.num_trials = 4'(ntr);
        bus.thresh_lo  = 8'(lo);
        bus.thresh_hi  = 8'(hi);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.num_trials = 4'($urandom_range(0, 15));
        bus.thresh_lo  = 8'($urandom_range(0, 255));
        bus.thresh_hi  = 8'($urandom_range(0, 255));
        check_eq({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            if (bus.done) seen = 1'b1;
            else begin
                bus.start = (cyc == extra_at);
                @(negedge clk);
                cyc++;
            end
        end
        bus.start    = 1'b0;
        last_latency = cyc;
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
        check_eq({tag, "_sum"}, 32'(bus.result_sum), 32'(e_sum));
        check_eq({tag, "_min"}, 32'(bus.result_min), 32'(e_min));
        check_eq({tag, "_max"}, 32'(bus.result_max), 32'(e_max));
        check_eq({tag, "_timeout"}, 32'(bus.timeout), 32'(e_to));
        check_eq({tag, "_alarm"}, 32'(bus.alarm), 32'(e_al));
        check_eq({tag, "_pin_at_done"}, 32'(path_input), 32'd0);
        bus.start = start_on_done;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_pin_after"}, 32'(path_input), 32'd0);
        check_eq({tag, "_sum_hold"}, 32'(bus.result_sum), 32'(e_sum));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s, mn, mx, ntr, lo, hi, dc0;
        bit al;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, mn, mx, ntr, lo, hi, dc0;
        bit al;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.num_trials = 4'd0;
        bus.thresh_lo = 8'd0;
        bus.thresh_hi = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_sum", 32'(bus.result_sum), 32'd0);
        check_eq("rst_min", 32'(bus.result_min), 32'd0);
        check_eq("rst_max", 32'(bus.result_max), 32'd0);
        check_eq("rst_flags", {30'd0, bus.timeout, bus.alarm}, 32'd0);
        check_eq("rst_pin", 32'(path_input), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // zero-delay loopback; a start held during the done cycle must be ignored
        rise_d = 0; fall_d = 0;
        run_meas("loop", 4, 1, 3, 0, 1'b1, 8, 2, 2, 1'b0, 1'b0);
        repeat (25) @(negedge clk);
        check_eq("loop_start_on_done_ignored", 32'(bus.busy), 32'd0);

        // 5-cycle symmetric delay, window too tight
        rise_d = 5; fall_d = 5;
        run_meas("d5", 3, 0, 6, 0, 1'b0, 21, 7, 7, 1'b0, 1'b1);

        // asymmetric rise 3 / fall 6
        rise_d = 3; fall_d = 6;
        model(2, 0, 20, s, mn, mx, al);
        check_eq("asym_model_sum", 32'(s), 32'd13);
        run_meas("asym", 2, 0, 20, 0, 1'b0, s, mn, mx, 1'b0, al);

        // randomized delays, trial counts and threshold windows
        for (int it = 0; it < 10; it++) begin
            rise_d = $urandom_range(0, 7);
            fall_d = $urandom_range(0, 7);
            ntr    = $urandom_range(0, 7);
            lo     = $urandom_range(0, 6);
            hi     = $urandom_range(3, 10);
            model(ntr, lo, hi, s, mn, mx, al);
            run_meas($sformatf("rnd%0d", it), ntr, lo, hi, 0, 1'b0, s, mn, mx, 1'b0, al);
        end

        // stuck-at-0 output: settle mismatch on the first trial
        stuck_en = 1'b1; stuck_val = 1'b0;
        run_meas("stuck0", 3, 0, 255, 0, 1'b0, 0, 0, 0, 1'b1, 1'b1);

        // settled before launch but never toggles: WAIT gives up after 200 cycles
        stuck_val = 1'b1;
        run_meas("stuck1", 3, 0, 255, 0, 1'b0, 0, 0, 0, 1'b1, 1'b1);
        check_eq("stuck1_waited_limit", 32'(last_latency >= 200), 32'd1);
        stuck_en = 1'b0;
        repeat (20) @(negedge clk);

        // num_trials = 0 runs one trial; a second start mid-run is ignored
        rise_d = 3; fall_d = 3;
        dc0 = done_cnt;
        run_meas("n0", 0, 0, 255, 8, 1'b0, 5, 5, 5, 1'b0, 1'b0);
        repeat (60) @(negedge clk);
        check_eq("n0_single_done", 32'(done_cnt - dc0), 32'd1);
        check_eq("n0_idle", 32'(bus.busy), 32'd0);

        // asynchronous reset during WAIT of a new run
        rise_d = 7; fall_d = 7;
        dc0 = done_cnt;
        bus.num_trials = 4'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check_eq("rstrun_pin_high", 32'(path_input), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstrun_pin", 32'(path_input), 32'd0);
        check_eq("rstrun_busy", 32'(bus.busy), 32'd0);
        check_eq("rstrun_sum", 32'(bus.result_sum), 32'd0);
        check_eq("rstrun_minmax", {16'd0, bus.result_min, bus.result_max}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("rstrun_no_done", 32'(done_cnt - dc0), 32'd0);

        // normal operation after reset
        rise_d = 2; fall_d = 4;
        model(3, 4, 6, s, mn, mx, al);
        run_meas("post_rst", 3, 4, 6, 0, 1'b0, s, mn, mx, 1'b0, al);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
